// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with held grants and registered one-hot/index outputs.
// Optional grant-hold limit enabled by defining ARB_TIMEOUT_EN (limit set by MAX_HOLD).
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_r, state_s;
  logic [2:0] ptr_r, ptr_s;
  logic [7:0] gnt_s;
  logic [2:0] gnt_id_s;
  logic       gnt_valid_s;
  logic       timeout_s;
  logic [2:0] winner_s;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_r, hold_s;
`endif

  // First set bit found scanning upward from p, wrapping past bit 7.
  function automatic logic [2:0] pick_winner(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    pick_winner = p;
    for (int i = 7; i >= 0; i--) begin
      idx = p + 3'(i);
      if (r[idx]) begin
        pick_winner = idx;
      end else begin
        pick_winner = pick_winner;
      end
    end
  endfunction

  assign winner_s = pick_winner(req, ptr_r);

  // Next-state and next-output decode.
  always_comb begin
    state_s     = state_r;
    ptr_s       = ptr_r;
    gnt_s       = gnt;
    gnt_id_s    = gnt_id;
    gnt_valid_s = gnt_valid;
    timeout_s   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_s      = hold_r;
`endif
    case (state_r)
      IDLE: begin
        if (req != 8'h00) begin
          state_s     = GRANT;
          gnt_s       = 8'h01 << winner_s;
          gnt_id_s    = winner_s;
          gnt_valid_s = 1'b1;
`ifdef ARB_TIMEOUT_EN
          hold_s      = 8'd0;
`endif
        end else begin
          gnt_s       = 8'h00;
          gnt_valid_s = 1'b0;
        end
      end
      GRANT: begin
        // Release wins over expiry, so a timeout only fires while req is still held.
        if (!req[gnt_id]) begin
          state_s     = IDLE;
          ptr_s       = gnt_id + 3'd1;
          gnt_s       = 8'h00;
          gnt_valid_s = 1'b0;
`ifdef ARB_TIMEOUT_EN
        end else if (hold_r == HOLD_LAST) begin
          state_s     = IDLE;
          ptr_s       = gnt_id + 3'd1;
          gnt_s       = 8'h00;
          gnt_valid_s = 1'b0;
          timeout_s   = 1'b1;
        end else begin
          hold_s      = hold_r + 8'd1;
`else
        end else begin
          state_s     = GRANT;
`endif
        end
      end
      default: begin
        state_s     = IDLE;
        gnt_s       = 8'h00;
        gnt_valid_s = 1'b0;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= 3'd0;
      gnt       <= 8'h00;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_r    <= 8'd0;
`endif
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      gnt       <= gnt_s;
      gnt_id    <= gnt_id_s;
      gnt_valid <= gnt_valid_s;
      timeout   <= timeout_s;
`ifdef ARB_TIMEOUT_EN
      hold_r    <= hold_s;
`endif
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: vector table plus hand-written sequences,
// expectations queued at drive time and compared after each clock edge.
module tb_rr_arbiter8;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TB_HOLD = 4;
`else
  localparam int unsigned TB_HOLD = 16;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       tmo;
  } vec_t;

  typedef struct {
    logic [7:0] gnt;
    logic [2:0] id;
    logic       valid;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[24];
  int   errors = 0;
  int   checks = 0;

  rr_arbiter8 #(.MAX_HOLD(TB_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h want %h", name, tag, act, exp);
    end
  endtask

  int step_no = 0;

  task automatic step(input logic r, input logic [7:0] q, input logic [7:0] eg,
                      input logic [2:0] ei, input logic ev, input logic et);
    exp_t e;
    rst = r;
    req = q;
    e.gnt = eg; e.id = ei; e.valid = ev; e.tmo = et;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("gnt", step_no, gnt, e.gnt);
    check("gnt_id", step_no, {5'd0, gnt_id}, {5'd0, e.id});
    check("gnt_valid", step_no, {7'd0, gnt_valid}, {7'd0, e.valid});
    check("timeout", step_no, {7'd0, timeout}, {7'd0, e.tmo});
    check("onehot_vs_id", step_no, gnt, {7'd0, gnt_valid} << gnt_id);
    step_no++;
  endtask

  initial begin
    logic [7:0] one;
    logic [7:0] bitk;
    int id;
    one = 8'h01;
    rst = 1'b1;
    req = 8'h00;

    vecs[0]  = '{1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h40, 8'h40, 3'd6, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 8'h00, 3'd6, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'h21, 8'h01, 3'd0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h20, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 8'h00, 3'd5, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 8'hFF, 8'h08, 3'd3, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 8'hFF, 8'h08, 3'd3, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 8'hF7, 8'h00, 3'd3, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 8'hF7, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 8'h10, 8'h00, 3'd0, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 8'h00, 8'h00, 3'd4, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 8'h00, 8'h00, 3'd4, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 8'h10, 8'h10, 3'd4, 1'b1, 1'b0};
    vecs[23] = '{1'b0, 8'h00, 8'h00, 3'd4, 1'b0, 1'b0};

    for (int i = 0; i < 24; i++) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].gnt, vecs[i].id, vecs[i].valid, vecs[i].tmo);
    end

    // All eight requesting; each releases for one cycle after two grant cycles.
    step(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) begin
      id = k % 8;
      bitk = one << id;
      step(1'b0, 8'hFF, bitk, 3'(id), 1'b1, 1'b0);
      step(1'b0, 8'hFF, bitk, 3'(id), 1'b1, 1'b0);
      step(1'b0, 8'hFF & ~bitk, 8'h00, 3'(id), 1'b0, 1'b0);
    end

`ifdef ARB_TIMEOUT_EN
    step(1'b1, 8'h03, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0);
    step(1'b0, 8'h03, 8'h00, 3'd0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b0, 8'h03, 8'h02, 3'd1, 1'b1, 1'b0);
    step(1'b0, 8'h03, 8'h00, 3'd1, 1'b0, 1'b1);
    step(1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0);
    // Release on the expiry cycle suppresses the timeout pulse.
    step(1'b1, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 8'h01, 8'h01, 3'd0, 1'b1, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
`else
    step(1'b1, 8'h03, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 24; k++) step(1'b0, 8'h03, 8'h01, 3'd0, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource among 8 requesters.
- Rotating-priority search over req[7:0] produces a one-hot grant and a 3-bit encoded grant index.
- Grant is held until the winner drops its request.
- Sits in front of any shared datapath (bus, memory port, display mux) and supplies the index for downstream select logic.

Parameters:
MAX_HOLD, 16, max consecutive cycles a grant may be held; used only when ARB_TIMEOUT_EN is defined; legal range 1..255.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req  input  8  request lines; bit i = requester i; level-sensitive, held high for as long as access is wanted
gnt  output  8  one-hot grant, registered; all-zero when no grant
gnt_id  output  3  binary index of granted requester, registered; valid only when gnt_valid=1
gnt_valid  output  1  high while any grant is active (equals |gnt)
timeout  output  1  one-cycle pulse when a grant is forcibly revoked; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset: clk and rst as named above; reset is synchronous and active-high, single clock domain.
- Reset values: gnt=8'h00, gnt_id=3'd0, gnt_valid=0, timeout=0, state=IDLE, ptr=3'd0, hold counter=0.
- Reset asserted mid-grant drops gnt on the next edge with no further handshake.
- State IDLE:
  - If req==0, stay in IDLE.
  - Otherwise select a winner, go to GRANT, and register gnt/gnt_id/gnt_valid. Latency is 1 cycle from the sampled req to the visible grant.
- Winner selection: search bits ptr, ptr+1, ..., ptr+7 (mod 8); the first bit that is set wins.
- State GRANT:
  - While req[gnt_id]=1, hold gnt unchanged. Changes on other req bits are ignored.
  - When req[gnt_id]=0 is sampled: next edge gnt=0, gnt_valid=0, state=IDLE, ptr=(gnt_id+1) mod 8.
  - gnt_id keeps its last value while invalid.
- Turnaround: exactly one idle cycle (gnt=0) between consecutive grants, always, including when a new grant goes back to the same requester.
- Fairness: ptr advances only on release or timeout. With all 8 requesting continuously, grant order from reset is 0,1,2,...,7,0.
- Wrap-around: ptr = 7 + 1 wraps to 0. The search from ptr=5 checks bits 5,6,7,0,1,2,3,4.
- Simultaneous release and new request from the same requester in one cycle cannot happen (level-sensitive). A requester that drops for 1 cycle and reasserts is rearbitrated normally.
- Encoding: gnt is always one-hot or zero. gnt == (gnt_valid << gnt_id) must hold every cycle.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - A grant is visible for at most MAX_HOLD cycles. In the cycle the grant has been visible for MAX_HOLD cycles with req[gnt_id] still 1, the grant is revoked: next edge gnt=0, state=IDLE, ptr=(gnt_id+1) mod 8, timeout=1 for that one cycle.
  - Normal release in the same cycle as expiry takes precedence: no timeout pulse.
- Undefined: no counter; grants are held indefinitely; timeout tied to 0.

Test Plan:
- Reset, then req=8'h01 at cycle 0 -> gnt=8'h01, gnt_id=0, gnt_valid=1 at cycle 1; drop req at cycle 4 -> gnt=0 at cycle 5.
- req=8'hFF held constantly from reset -> gnt_id sequence 0,1,2,...,7,0. Each requester releases after 2 grant cycles then reasserts. One zero-gnt cycle between each grant.
- After grant to 6 and release (ptr=7), req=8'h21 -> next grant id 0 (wrap past 7), then 5.
- During a grant to 3, assert req=8'hFF -> gnt stays 8'h08 until req[3] drops. Next grant is id 4.
- rst pulsed while gnt=8'h10 -> next cycle gnt=0, gnt_valid=0. With req=8'h10 still high, grant to 4 again 1 cycle after rst deasserts (ptr=0, bits 0..3 clear).
- ARB_TIMEOUT_EN, MAX_HOLD=4, req=8'h03 held -> gnt=8'h01 for exactly 4 cycles, timeout=1 one cycle, then gnt=8'h02. Without the macro, gnt=8'h01 persists indefinitely and timeout stays 0.
